// File: rtl/tfhe_axi_wr_burst_engine.sv
// Write-back DMA: buffers the PBS result stream and emits fixed-length AXI4 INCR write bursts.
// Optional macro TFHE_WR_BRESP_CHECK_EN enables the sticky o_error flag on non-OKAY BRESP.
module tfhe_axi_wr_burst_engine #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 256,
  parameter int C_M_AXI_BURST_LEN  = 16,
  parameter int FIFO_DEPTH         = 32,
  parameter int MAX_OUTSTANDING    = 4
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_cmd_valid,
  output logic                          o_cmd_ready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [15:0]                   i_cmd_nbursts,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] i_s_tdata,
  input  logic                          i_s_tvalid,
  output logic                          o_s_tready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic                          M_AXI_WLAST,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_error,
  output logic                          o_dbg_state
);

  localparam int BURST_BYTES = C_M_AXI_BURST_LEN * C_M_AXI_DATA_WIDTH / 8;
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W       = $clog2(MAX_OUTSTANDING + 1);
  localparam int BEAT_W      = $clog2(C_M_AXI_BURST_LEN);
  localparam int TOT_W       = 16 + BEAT_W;

  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_INC  = C_M_AXI_ADDR_WIDTH'(BURST_BYTES);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_MASK = ~(C_M_AXI_ADDR_WIDTH'(BURST_BYTES - 1));
  localparam logic [CNT_W-1:0]  BL_C      = CNT_W'(C_M_AXI_BURST_LEN);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [OUT_W-1:0]  MAX_C     = OUT_W'(MAX_OUTSTANDING);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(C_M_AXI_BURST_LEN - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Handshakes: a transfer happens on any rising clock edge where valid and ready are
  // both high; a source holds valid and its payload stable until that edge.
  state_t state_q, state_d;

  logic [C_M_AXI_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  reserved_q, reserved_d;
  logic [CNT_W-1:0]  unreserved_d;
  logic [OUT_W-1:0]  outstanding_q, outstanding_d;
  logic [OUT_W-1:0]  w_pend_q, w_pend_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [15:0]       aw_rem_q, aw_rem_d;
  logic [15:0]       w_rem_q, w_rem_d;
  logic [15:0]       b_rem_q, b_rem_d;
  logic [TOT_W-1:0]  beats_in_q, beats_in_d;
  logic [TOT_W-1:0]  limit_q, limit_d;
  logic              aw_issue_d;

  logic cmd_hs, s_hs, aw_hs, w_hs, w_last_hs, b_hs;

  assign cmd_hs    = i_cmd_valid & o_cmd_ready;
  assign s_hs      = i_s_tvalid & o_s_tready;
  assign aw_hs     = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs      = M_AXI_WVALID & M_AXI_WREADY;
  assign w_last_hs = w_hs & M_AXI_WLAST;
  assign b_hs      = M_AXI_BVALID & M_AXI_BREADY;

  assign o_dbg_state = state_q;
  assign M_AXI_WDATA = (count_q == '0) ? '0 : mem[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_hs && (i_cmd_nbursts != 16'd0)) state_d = RUN;
      RUN:     if (b_hs && (b_rem_q == 16'd1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (s_hs && !w_hs)      count_d = count_q + CNT_W'(1);
    else if (!s_hs && w_hs) count_d = count_q - CNT_W'(1);

    // Beats already promised to an issued AW but not yet sent on W.
    reserved_d = reserved_q;
    if (aw_hs) reserved_d = reserved_d + BL_C;
    if (w_hs)  reserved_d = reserved_d - CNT_W'(1);
    unreserved_d = count_d - reserved_d;

    outstanding_d = outstanding_q;
    if (aw_hs && !b_hs)      outstanding_d = outstanding_q + OUT_W'(1);
    else if (!aw_hs && b_hs) outstanding_d = outstanding_q - OUT_W'(1);

    w_pend_d = w_pend_q;
    if (aw_hs)     w_pend_d = w_pend_d + OUT_W'(1);
    if (w_last_hs) w_pend_d = w_pend_d - OUT_W'(1);

    beat_d = beat_q;
    if (w_hs) beat_d = (beat_q == BEAT_LAST) ? '0 : beat_q + BEAT_W'(1);

    aw_rem_d = aw_rem_q;
    w_rem_d  = w_rem_q;
    b_rem_d  = b_rem_q;
    beats_in_d = beats_in_q;
    limit_d    = limit_q;
    if (cmd_hs) begin
      aw_rem_d   = i_cmd_nbursts;
      w_rem_d    = i_cmd_nbursts;
      b_rem_d    = i_cmd_nbursts;
      beats_in_d = '0;
      limit_d    = {i_cmd_nbursts, BEAT_W'(0)};
    end else begin
      if (aw_hs)                         aw_rem_d   = aw_rem_q - 16'd1;
      if (w_last_hs)                     w_rem_d    = w_rem_q - 16'd1;
      if (b_hs && (b_rem_q != 16'd0))    b_rem_d    = b_rem_q - 16'd1;
      if (s_hs)                          beats_in_d = beats_in_q + TOT_W'(1);
    end

    aw_issue_d = (state_d == RUN) && (aw_rem_d != 16'd0) &&
                 (unreserved_d >= BL_C) && (outstanding_d < MAX_C);
  end

  always_ff @(posedge i_clk) begin
    if (s_hs) mem[wr_ptr_q] <= i_s_tdata;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      reserved_q    <= '0;
      outstanding_q <= '0;
      w_pend_q      <= '0;
      beat_q        <= '0;
      aw_rem_q      <= '0;
      w_rem_q       <= '0;
      b_rem_q       <= '0;
      beats_in_q    <= '0;
      limit_q       <= '0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_WLAST   <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      o_cmd_ready   <= 1'b1;
      o_s_tready    <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      reserved_q    <= reserved_d;
      outstanding_q <= outstanding_d;
      w_pend_q      <= w_pend_d;
      beat_q        <= beat_d;
      aw_rem_q      <= aw_rem_d;
      w_rem_q       <= w_rem_d;
      b_rem_q       <= b_rem_d;
      beats_in_q    <= beats_in_d;
      limit_q       <= limit_d;
      if (s_hs) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (w_hs) rd_ptr_q <= rd_ptr_q + PTR_W'(1);

      if (cmd_hs)     M_AXI_AWADDR <= i_cmd_addr & ADDR_MASK;
      else if (aw_hs) M_AXI_AWADDR <= M_AXI_AWADDR + ADDR_INC;
      // A stalled AW keeps its valid; otherwise re-evaluate credit for the next burst.
      if (!(M_AXI_AWVALID && !M_AXI_AWREADY)) M_AXI_AWVALID <= aw_issue_d;

      M_AXI_WVALID <= (w_pend_d != '0);
      M_AXI_WLAST  <= (w_pend_d != '0) && (beat_d == BEAT_LAST);
      M_AXI_BREADY <= (state_d == RUN);
      o_cmd_ready  <= (state_d == IDLE);
      o_busy       <= (state_d == RUN);
      o_s_tready   <= (state_d == RUN) && (count_d < DEPTH_C) && (beats_in_d < limit_d);
      o_done       <= (cmd_hs && (i_cmd_nbursts == 16'd0)) ||
                      ((state_q == RUN) && b_hs && (b_rem_q == 16'd1));
    end
  end

`ifdef TFHE_WR_BRESP_CHECK_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                               o_error <= 1'b0;
    else if (cmd_hs)                              o_error <= 1'b0;
    else if (b_hs && (M_AXI_BRESP != 2'b00))      o_error <= 1'b1;
  end
`else
  logic unused_bresp;
  assign unused_bresp = ^M_AXI_BRESP;
  assign o_error      = 1'b0;
`endif

endmodule

// File: tb/tb_tfhe_axi_wr_burst_engine.sv
// Directed bench for tfhe_axi_wr_burst_engine: AXI slave model, stream driver, scoreboard.
module tb_tfhe_axi_wr_burst_engine;

  localparam int AW = 64;
  localparam int DW = 256;
`ifdef TFHE_WR_BRESP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_cmd_valid = 1'b0;
  logic          o_cmd_ready;
  logic [AW-1:0] i_cmd_addr = '0;
  logic [15:0]   i_cmd_nbursts = '0;
  logic [DW-1:0] i_s_tdata = '0;
  logic          i_s_tvalid = 1'b0;
  logic          o_s_tready;
  logic [AW-1:0] M_AXI_AWADDR;
  logic          M_AXI_AWVALID;
  logic          M_AXI_AWREADY = 1'b1;
  logic [DW-1:0] M_AXI_WDATA;
  logic          M_AXI_WLAST;
  logic          M_AXI_WVALID;
  logic          M_AXI_WREADY = 1'b1;
  logic [1:0]    M_AXI_BRESP = 2'b00;
  logic          M_AXI_BVALID = 1'b0;
  logic          M_AXI_BREADY;
  logic          o_busy, o_done, o_error, o_dbg_state;

  tfhe_axi_wr_burst_engine dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_addr(i_cmd_addr), .i_cmd_nbursts(i_cmd_nbursts),
    .i_s_tdata(i_s_tdata), .i_s_tvalid(i_s_tvalid), .o_s_tready(o_s_tready),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_dbg_state(o_dbg_state)
  );

  // clock / cycle counter
  always #5 i_clk = ~i_clk;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // slave-model knobs, written by the main sequence only
  logic model_clr = 1'b1;
  logic rand_mode = 1'b0;
  logic b_en = 1'b1;
  int   err_idx = -1;
  int   beat_id = 0;

  // monitor state, written by the monitor only
  logic [AW-1:0] aw_q[$];
  int            aw_hs_cyc_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] w_q[$];
  int aw_cnt = 0, w_cnt = 0, wlast_cnt = 0, b_cnt = 0, s_cnt = 0, done_cnt = 0;
  int first_b_cyc = -1, beat16_cyc = -1, done_cyc = -1;
  int stab_viol = 0, aw_early = 0, w_early = 0, wlast_viol = 0;
  logic          aw_stall_q = 1'b0, w_stall_q = 1'b0, w_last_q = 1'b0;
  logic [AW-1:0] aw_addr_q = '0;
  logic [DW-1:0] w_data_q = '0;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // AXI slave: readies and B responses, updated just after each rising edge
  always @(posedge i_clk) begin
    #1;
    M_AXI_AWREADY = rand_mode ? ($urandom_range(0, 9) >= 3) : 1'b1;
    M_AXI_WREADY  = rand_mode ? ($urandom_range(0, 9) >= 3) : 1'b1;
    M_AXI_BVALID  = b_en && (wlast_cnt > b_cnt);
    M_AXI_BRESP   = (b_cnt == err_idx) ? 2'b10 : 2'b00;
  end

  // monitor / scoreboard capture at the falling edge
  always @(negedge i_clk) begin
    if (model_clr) begin
      aw_q.delete(); aw_hs_cyc_q.delete(); exp_q.delete(); w_q.delete();
      aw_cnt <= 0; w_cnt <= 0; wlast_cnt <= 0; b_cnt <= 0; s_cnt <= 0; done_cnt <= 0;
      first_b_cyc <= -1; beat16_cyc <= -1; done_cyc <= -1;
      stab_viol <= 0; aw_early <= 0; w_early <= 0; wlast_viol <= 0;
      aw_stall_q <= 1'b0; w_stall_q <= 1'b0;
    end else begin
      if ((aw_stall_q && (!M_AXI_AWVALID || M_AXI_AWADDR !== aw_addr_q)) ||
          (w_stall_q && (!M_AXI_WVALID || M_AXI_WDATA !== w_data_q || M_AXI_WLAST !== w_last_q)))
        stab_viol <= stab_viol + 1;
      aw_stall_q <= M_AXI_AWVALID && !M_AXI_AWREADY;
      aw_addr_q  <= M_AXI_AWADDR;
      w_stall_q  <= M_AXI_WVALID && !M_AXI_WREADY;
      w_data_q   <= M_AXI_WDATA;
      w_last_q   <= M_AXI_WLAST;
      if (M_AXI_AWVALID && (s_cnt < 16 * (aw_cnt + 1))) aw_early <= aw_early + 1;
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        if (M_AXI_WLAST !== ((w_cnt % 16) == 15)) wlast_viol <= wlast_viol + 1;
        if (w_cnt >= 16 * aw_cnt) w_early <= w_early + 1;
        w_q.push_back(M_AXI_WDATA);
        w_cnt <= w_cnt + 1;
        if (M_AXI_WLAST) wlast_cnt <= wlast_cnt + 1;
      end
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        aw_q.push_back(M_AXI_AWADDR);
        aw_hs_cyc_q.push_back(cyc);
        aw_cnt <= aw_cnt + 1;
      end
      if (M_AXI_BVALID && M_AXI_BREADY) begin
        if (b_cnt == 0) first_b_cyc <= cyc;
        b_cnt <= b_cnt + 1;
      end
      if (i_s_tvalid && o_s_tready) begin
        exp_q.push_back(i_s_tdata);
        if (s_cnt == 15) beat16_cyc <= cyc;
        s_cnt <= s_cnt + 1;
      end
      if (o_done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
  end

  // driver tasks
  function automatic logic [DW-1:0] mk_data(input int id);
    logic [DW-1:0] d;
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = 32'hC0DE_0000 + 32'(id * 8 + k);
    return d;
  endfunction

  task automatic clr_model();
    model_clr = 1'b1;
    @(negedge i_clk);
    #1 model_clr = 1'b0;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_cmd(input logic [AW-1:0] a, input logic [15:0] nb);
    int g = 0;
    i_cmd_valid = 1'b1; i_cmd_addr = a; i_cmd_nbursts = nb;
    @(negedge i_clk);
    while (!o_cmd_ready && g < 200) begin @(negedge i_clk); g++; end
    @(posedge i_clk);
    #1 i_cmd_valid = 1'b0;
  endtask

  task automatic stream(input int n, input int stall_at, input int stall_len);
    int sent = 0;
    int guard = 0;
    int sl = stall_len;
    while (sent < n && guard < 4000) begin
      if (sent == stall_at && sl > 0) begin
        i_s_tvalid = 1'b0;
        repeat (sl) @(posedge i_clk);
        #1 sl = 0;
      end
      i_s_tvalid = 1'b1;
      i_s_tdata  = mk_data(beat_id);
      @(negedge i_clk);
      if (o_s_tready) begin sent++; beat_id++; end
      @(posedge i_clk);
      #1 guard++;
    end
    i_s_tvalid = 1'b0;
    check("stream_beats", sent, n);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin @(negedge i_clk); n++; end
    check("done_seen", done_cnt != 0, 1'b1);
    repeat (3) @(negedge i_clk);
  endtask

  task automatic check_data();
    check("wbeat_count", w_q.size(), exp_q.size());
    for (int i = 0; i < w_q.size() && i < exp_q.size(); i++) check("wdata_order", w_q[i], exp_q[i]);
  endtask

  task automatic check_addrs(input logic [AW-1:0] base, input int n);
    logic [AW-1:0] e;
    check("aw_count", aw_q.size(), n);
    for (int k = 0; k < n && k < aw_q.size(); k++) begin
      e = base + AW'(k) * AW'(512);
      check("awaddr", aw_q[k], e);
    end
  endtask

  task automatic check_protocol(input int nb);
    check("w_beats", w_cnt, nb * 16);
    check("wlast_bursts", wlast_cnt, nb);
    check("b_count", b_cnt, nb);
    check("wlast_position", wlast_viol, 0);
    check("w_before_aw", w_early, 0);
    check("aw_credit", aw_early, 0);
    check("done_once", done_cnt, 1);
    check("busy_after", o_busy, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check("rst_awvalid", M_AXI_AWVALID, 1'b0);
    check("rst_wvalid", M_AXI_WVALID, 1'b0);
    check("rst_wlast", M_AXI_WLAST, 1'b0);
    check("rst_bready", M_AXI_BREADY, 1'b0);
    check("rst_tready", o_s_tready, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_error", o_error, 1'b0);
    check("rst_awaddr", M_AXI_AWADDR, '0);
    check("rst_wdata", M_AXI_WDATA, '0);
    check("rst_cmd_ready", o_cmd_ready, 1'b1);
  endtask

  initial begin
    // reset
    repeat (3) @(posedge i_clk);
    #1 check_reset_outputs();
    @(negedge i_clk);
    i_reset_n = 1'b1;
    clr_model();

    // single burst
    do_cmd(64'h1000, 16'd1);
    check("run_after_cmd", o_busy, 1'b1);
    check("cmd_ready_run", o_cmd_ready, 1'b0);
    stream(16, -1, 0);
    wait_done(300);
    check_addrs(64'h1000, 1);
    check_protocol(1);
    check("done_after_b", done_cyc - first_b_cyc, 1);
    check("error_clean", o_error, 1'b0);
    check_data();

    // multi-burst with credit gating; unaligned low bits are dropped
    clr_model();
    do_cmd(64'h1A5, 16'd4);
    stream(64, 15, 20);
    wait_done(600);
    check_addrs(64'h0, 4);
    check_protocol(4);
    check("aw_after_beat16", aw_hs_cyc_q.size() > 0 ? aw_hs_cyc_q[0] - beat16_cyc : -1, 1);
    check_data();

    // outstanding limit
    clr_model();
    b_en = 1'b0;
    do_cmd(64'h8000, 16'd8);
    stream(96, -1, 0);
    repeat (20) @(negedge i_clk);
    check("aw_held_at_limit", aw_cnt, 4);
    check("awvalid_low_limit", M_AXI_AWVALID, 1'b0);
    check("w_beats_at_limit", w_cnt, 64);
    @(posedge i_clk);
    #1 b_en = 1'b1;
    stream(32, -1, 0);
    wait_done(800);
    check("aw5_after_b1", aw_hs_cyc_q.size() > 4 ? aw_hs_cyc_q[4] - first_b_cyc : -1, 1);
    check_addrs(64'h8000, 8);
    check_protocol(8);
    check_data();

    // backpressure on AW and W
    clr_model();
    rand_mode = 1'b1;
    do_cmd(64'h2_0000, 16'd3);
    stream(48, -1, 0);
    wait_done(2000);
    rand_mode = 1'b0;
    check("stable_under_stall", stab_viol, 0);
    check_addrs(64'h2_0000, 3);
    check_protocol(3);
    check_data();

    // bad BRESP on burst 2
    clr_model();
    err_idx = 1;
    do_cmd(64'h4000, 16'd3);
    stream(48, -1, 0);
    wait_done(600);
    err_idx = -1;
    check_protocol(3);
    check("error_flag", o_error, EXP_ERR);
    repeat (5) @(negedge i_clk);
    check("error_sticky", o_error, EXP_ERR);

    // nbursts = 0: immediate done, no AXI traffic, error cleared by the new command
    clr_model();
    do_cmd(64'h7000, 16'd0);
    check("zero_done_n1", o_done, 1'b1);
    check("zero_error_clr", o_error, 1'b0);
    check("zero_idle", o_busy, 1'b0);
    @(posedge i_clk);
    #1 check("zero_done_pulse", o_done, 1'b0);
    repeat (10) @(negedge i_clk);
    check("zero_no_aw", aw_cnt, 0);
    check("zero_no_w", w_cnt, 0);
    check("zero_cmd_ready", o_cmd_ready, 1'b1);

    // reset during burst 2
    clr_model();
    do_cmd(64'h4_0000, 16'd3);
    stream(32, -1, 0);
    begin
      int g = 0;
      while (aw_cnt < 2 && g < 500) begin @(negedge i_clk); g++; end
    end
    check("reached_burst2", aw_cnt >= 2, 1'b1);
    #2 i_reset_n = 1'b0;
    #1 check_reset_outputs();
    @(negedge i_clk);
    i_reset_n = 1'b1;
    clr_model();
    do_cmd(64'hFFFF_FFFF_FFFF_FE00, 16'd2);
    stream(32, -1, 0);
    wait_done(600);
    check_addrs(64'hFFFF_FFFF_FFFF_FE00, 2);
    check_protocol(2);
    check_data();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout obs=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
